// File: rtl/load_store_unit.sv
// Data-memory initiator: turns RV32 load/store requests into word-aligned transfers
// with byte enables, splitting word-crossing accesses into two back-to-back transfers.
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    state_t        state;
    logic          req_store;
    logic [2:0]    req_f3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic [31:0]   lo_word;
    logic [CW-1:0] wait_cnt;

    logic [1:0]    sel_sz;
    logic [1:0]    sel_off;
    logic [31:0]   sel_wdata;
    logic [7:0]    span;
    logic [63:0]   wide;
    logic [55:0]   asm_bytes;
    logic [31:0]   raw;
    logic [31:0]   load_val;

    function automatic logic legal_req(input logic st, input logic [2:0] f3);
        logic ok;
        ok = (f3[1:0] != 2'b11);
        if (st && f3[2])
            ok = 1'b0;
        if (!st && f3[2] && f3[1])
            ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [7:0] lane_span(input logic [1:0] sz, input logic [1:0] off);
        logic [7:0] m;
        case (sz)
            2'b00:   m = 8'h01;
            2'b01:   m = 8'h03;
            default: m = 8'h0F;
        endcase
        return m << off;
    endfunction

    // In IDLE the lanes come straight from the request inputs so the first transfer
    // can be registered on the accepting edge; afterwards from the captured request.
    always_comb begin
        if (state == IDLE) begin
            sel_sz    = funct3[1:0];
            sel_off   = addr[1:0];
            sel_wdata = wdata;
        end else begin
            sel_sz    = req_f3[1:0];
            sel_off   = req_addr[1:0];
            sel_wdata = req_wdata;
        end
        span = lane_span(sel_sz, sel_off);
        wide = {32'b0, sel_wdata} << {sel_off, 3'b000};
    end

    // Bytes above lane 2 of the second word can never belong to a split access.
    always_comb begin
        if (state == ACC1)
            asm_bytes = {mem_rdata[23:0], lo_word};
        else
            asm_bytes = {24'b0, mem_rdata};
        case (req_addr[1:0])
            2'd0:    raw = asm_bytes[31:0];
            2'd1:    raw = asm_bytes[39:8];
            2'd2:    raw = asm_bytes[47:16];
            default: raw = asm_bytes[55:24];
        endcase
        case (req_f3)
            3'b000:  load_val = {{24{raw[7]}}, raw[7:0]};
            3'b001:  load_val = {{16{raw[15]}}, raw[15:0]};
            3'b100:  load_val = {24'b0, raw[7:0]};
            3'b101:  load_val = {16'b0, raw[15:0]};
            default: load_val = raw;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            req_store <= 1'b0;
            req_f3    <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            lo_word   <= '0;
            wait_cnt  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        req_store <= is_store;
                        req_f3    <= funct3;
                        req_addr  <= addr;
                        req_wdata <= wdata;
                        wait_cnt  <= '0;
                        if (legal_req(is_store, funct3)) begin
                            state     <= ACC0;
                            busy      <= 1'b1;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_be    <= span[3:0];
                            mem_wdata <= wide[31:0];
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                            err   <= 1'b1;
                            rdata <= '0;
                        end
                    end
                end
                ACC0, ACC1: begin
                    if (mem_req && mem_ready) begin
                        wait_cnt <= '0;
                        if (state == ACC0 && span[7:4] != 4'b0000) begin
                            state     <= ACC1;
                            lo_word   <= mem_rdata;
                            mem_addr  <= {req_addr[31:2] + 30'd1, 2'b00};
                            mem_be    <= span[7:4];
                            mem_wdata <= wide[63:32];
                        end else begin
                            state   <= DONE;
                            busy    <= 1'b0;
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            mem_be  <= '0;
                            done    <= 1'b1;
                            err     <= 1'b0;
                            rdata   <= req_store ? 32'b0 : load_val;
                        end
                    end else if (wait_cnt == LIMIT) begin
                        // Responder never answered: abandon the access with an error.
                        state   <= DONE;
                        busy    <= 1'b0;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        mem_be  <= '0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                        rdata   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Randomized and directed bench for load_store_unit against a byte-level memory model
// and a wait-state responder kept inside the bench.
module tb_load_store_unit;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    int tests = 0;
    int fails = 0;

    int wait_cfg = 0;
    int wait_left = 0;
    bit stuck = 1'b0;
    bit in_xfer = 1'b0;
    logic [31:0] cur_addr;
    logic [31:0] cur_wdata;
    logic [3:0]  cur_be;
    logic        cur_we;
    logic [31:0] xq_addr[$];
    logic [31:0] xq_wdata[$];
    logic [3:0]  xq_be[$];
    logic        xq_we[$];
    logic [31:0] wmem [logic [29:0]];
    logic [7:0]  refmem [logic [31:0]];

    load_store_unit #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [31:0] init_word(input logic [29:0] w);
        return ({w, 2'b00} * 32'h9E3779B1) ^ 32'h5A5AA5A5;
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        if (refmem.exists(a))
            return refmem[a];
        w = init_word(a[31:2]);
        return w[{a[1:0], 3'b000} +: 8];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Responder: holds mem_ready low for wait_cfg cycles per transfer, then completes it.
    initial begin
        logic [31:0] w;
        forever begin
            @(negedge clk);
            if (mem_ready) begin
                mem_ready = 1'b0;
                wait_left = wait_cfg;
                in_xfer   = 1'b0;
            end
            if (rst && mem_req && !stuck) begin
                if (!in_xfer) begin
                    in_xfer   = 1'b1;
                    cur_addr  = mem_addr;
                    cur_be    = mem_be;
                    cur_we    = mem_we;
                    cur_wdata = mem_wdata;
                end
                if (wait_left > 0) begin
                    wait_left--;
                end else begin
                    checkOutput("stable_addr", mem_addr, cur_addr);
                    checkOutput("stable_be", {28'b0, mem_be}, {28'b0, cur_be});
                    checkOutput("stable_wdata", mem_wdata, cur_wdata);
                    xq_addr.push_back(mem_addr);
                    xq_be.push_back(mem_be);
                    xq_we.push_back(mem_we);
                    xq_wdata.push_back(mem_wdata);
                    w = wmem.exists(mem_addr[31:2]) ? wmem[mem_addr[31:2]] : init_word(mem_addr[31:2]);
                    mem_rdata = w;
                    if (mem_we) begin
                        for (int k = 0; k < 4; k++)
                            if (mem_be[k])
                                w[8*k +: 8] = mem_wdata[8*k +: 8];
                        wmem[mem_addr[31:2]] = w;
                    end
                    mem_ready = 1'b1;
                end
            end
        end
    end

    task automatic applyStimulus(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input int waits, input bit poke);
        int s, n, exp_lat, cyc, reqs, nbusy;
        bit legal, to, got;
        logic [29:0] ew [2];
        logic [3:0]  ebe [2];
        logic [63:0] wide;
        logic [31:0] exp_rd, ba, err_s, rd_s, busy_s;

        s = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = !(f3[1:0] == 2'b11 || (st && f3[2]) || (!st && f3 == 3'b110));
        to = stuck && legal;
        n = 0;
        if (legal) begin
            for (int i = 0; i < s; i++) begin
                ba = a + 32'(i);
                if (n == 0 || ew[n-1] != ba[31:2]) begin
                    ew[n]  = ba[31:2];
                    ebe[n] = 4'b0000;
                    n++;
                end
                ebe[n-1][ba[1:0]] = 1'b1;
            end
        end
        wide = {32'b0, wd} << {a[1:0], 3'b000};
        exp_rd = 32'h0;
        for (int i = 0; i < s; i++)
            exp_rd[8*i +: 8] = ref_byte(a + 32'(i));
        if (!f3[2] && s == 1 && exp_rd[7])
            exp_rd = exp_rd | 32'hFFFFFF00;
        if (!f3[2] && s == 2 && exp_rd[15])
            exp_rd = exp_rd | 32'hFFFF0000;
        exp_lat = !legal ? 1 : to ? int'(TO) + 1 : n * (waits + 1) + 1;

        wait_cfg = waits;
        wait_left = waits;
        in_xfer = 1'b0;
        xq_addr.delete();
        xq_be.delete();
        xq_we.delete();
        xq_wdata.delete();

        @(negedge clk);
        is_store = st;
        funct3 = f3;
        addr = a;
        wdata = wd;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;

        cyc = 0; reqs = 0; nbusy = 0; got = 1'b0;
        err_s = 0; rd_s = 0; busy_s = 0;
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (mem_req) reqs++;
            if (done) begin
                got = 1'b1;
                err_s = {31'b0, err};
                rd_s = rdata;
                busy_s = {31'b0, busy};
            end else begin
                if (busy) nbusy++;
                if (poke && cyc == 2) begin
                    start = 1'b1;
                    is_store = 1'($urandom);
                    funct3 = 3'($urandom);
                    addr = $urandom;
                    wdata = $urandom;
                end
                if (poke && cyc == 3)
                    start = 1'b0;
            end
        end
        start = 1'b0;

        checkOutput("done_seen", {31'b0, got}, 32'd1);
        checkOutput("latency", cyc, exp_lat);
        checkOutput("busy_span", nbusy, exp_lat - 1);
        checkOutput("done_busy_excl", busy_s, 32'd0);
        checkOutput("err", err_s, {31'b0, (!legal || to)});
        checkOutput("req_cycles", reqs, legal ? exp_lat - 1 : 0);
        if (to)
            checkOutput("timeout_rdata", rd_s, 32'h0);
        else if (legal && !st)
            checkOutput("load_rdata", rd_s, exp_rd);
        if (!to) begin
            checkOutput("xfer_count", 32'(xq_addr.size()), n);
            for (int k = 0; k < n && k < xq_addr.size(); k++) begin
                checkOutput("xfer_addr", xq_addr[k], {ew[k], 2'b00});
                checkOutput("xfer_be", {28'b0, xq_be[k]}, {28'b0, ebe[k]});
                checkOutput("xfer_we", {31'b0, xq_we[k]}, {31'b0, st});
                if (st)
                    checkOutput("xfer_wdata", xq_wdata[k], wide[32*k +: 32]);
            end
        end

        @(negedge clk);
        checkOutput("done_pulse", {31'b0, done}, 32'd0);
        if (legal && !st && !to)
            checkOutput("rdata_hold", rdata, exp_rd);

        if (legal && st && !to)
            for (int i = 0; i < s; i++)
                refmem[a + 32'(i)] = wd[8*i +: 8];
    endtask

    initial begin
        logic [2:0] ld_f3 [5];
        logic [2:0] st_f3 [3];
        logic [2:0] f3;
        logic [31:0] a;
        bit st;
        int guard;

        ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        st_f3 = '{3'b000, 3'b001, 3'b010};

        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_err", {31'b0, err}, 32'd0);
        checkOutput("rst_rdata", rdata, 32'd0);
        checkOutput("rst_mem_req", {31'b0, mem_req}, 32'd0);
        checkOutput("rst_mem_we", {31'b0, mem_we}, 32'd0);
        checkOutput("rst_mem_addr", mem_addr, 32'd0);
        checkOutput("rst_mem_be", {28'b0, mem_be}, 32'd0);
        checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;

        applyStimulus(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, 0, 1'b0);
        applyStimulus(1'b1, 3'b001, 32'h06, 32'h0000ABCD, 0, 1'b0);
        applyStimulus(1'b0, 3'b001, 32'h06, 32'h0, 0, 1'b0);
        applyStimulus(1'b0, 3'b101, 32'h06, 32'h0, 0, 1'b0);
        applyStimulus(1'b1, 3'b000, 32'h09, 32'h000000AA, 0, 1'b0);
        applyStimulus(1'b0, 3'b000, 32'h09, 32'h0, 0, 1'b0);
        applyStimulus(1'b0, 3'b100, 32'h09, 32'h0, 0, 1'b0);
        applyStimulus(1'b1, 3'b010, 32'h03, 32'h11223344, 0, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h03, 32'h0, 0, 1'b0);
        applyStimulus(1'b1, 3'b010, 32'h22, 32'hCAFEF00D, 3, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'h22, 32'h0, 3, 1'b0);
        applyStimulus(1'b0, 3'b011, 32'h10, 32'h0, 0, 1'b0);
        applyStimulus(1'b1, 3'b100, 32'h10, 32'h12345678, 0, 1'b0);
        applyStimulus(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, 1, 1'b0);

        stuck = 1'b1;
        applyStimulus(1'b0, 3'b010, 32'h40, 32'h0, 0, 1'b0);
        stuck = 1'b0;

        applyStimulus(1'b1, 3'b010, 32'h30, 32'h0BADCAFE, 3, 1'b1);
        applyStimulus(1'b0, 3'b010, 32'h30, 32'h0, 0, 1'b0);

        // Abort a split load while its second transfer is waiting.
        wait_cfg = 3;
        wait_left = 3;
        in_xfer = 1'b0;
        xq_addr.delete();
        xq_be.delete();
        xq_we.delete();
        xq_wdata.delete();
        @(negedge clk);
        is_store = 1'b0;
        funct3 = 3'b010;
        addr = 32'h21;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        guard = 0;
        while (xq_addr.size() < 1 && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("rst_first_xfer", 32'(xq_addr.size()), 32'd1);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_pre_req", {31'b0, mem_req}, 32'd1);
        #2 rst = 1'b0;
        #1;
        checkOutput("rst_mid_req", {31'b0, mem_req}, 32'd0);
        checkOutput("rst_mid_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_mid_done", {31'b0, done}, 32'd0);
        @(posedge clk);
        #2 rst = 1'b1;
        applyStimulus(1'b0, 3'b010, 32'h21, 32'h0, 0, 1'b0);

        for (int it = 0; it < 40; it++) begin
            st = 1'($urandom);
            if ($urandom % 10 == 0)
                f3 = st ? {1'b1, 2'($urandom)} : (($urandom % 2 == 0) ? 3'b011 : {2'b11, 1'($urandom)});
            else
                f3 = st ? st_f3[$urandom % 3] : ld_f3[$urandom % 5];
            a = ($urandom % 16 == 0) ? 32'hFFFFFFFC + 32'($urandom % 4) : 32'($urandom % 64);
            applyStimulus(st, f3, a, $urandom, int'($urandom % 4), 1'($urandom % 5 == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the data-memory interface: accepts one load or store request from the core, converts RV32 funct3 sizes (byte/half/word, signed/unsigned) into word-aligned memory transactions with byte enables, and returns the sign- or zero-extended load result. Accesses that cross a word boundary are split into two sequential aligned transfers. The unit sits between the execute stage and the data memory, and stalls the core through `busy` while memory wait states elapse.

## Interface
- `TIMEOUT`, default 255: maximum wait cycles per memory transfer before the request aborts with `err`.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `start` in 1: request strobe, sampled only in IDLE.
- `is_store` in 1: 1 = store, 0 = load.
- `funct3` in 3: 000 B, 001 H, 010 W, 100 BU, 101 HU. Stores accept only 000, 001 and 010.
- `addr` in 32: byte address, any alignment.
- `wdata` in 32: store data, right-justified.
- `busy` out 1: high from the cycle after an accepted `start` until `done`.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`. Set for an illegal funct3 or a timeout.
- `rdata` out 32: extended load data. Valid with `done` and held until the next accepted `start`.
- `mem_req` out 1: transfer request. Held high until the transfer completes.
- `mem_we` out 1: write transfer.
- `mem_addr` out 32: word-aligned address, low two bits always 00.
- `mem_be` out 4: byte enables. Bit i selects byte lane i (little-endian).
- `mem_wdata` out 32: lane-aligned write data.
- `mem_ready` in 1: responder accepts or completes the transfer.
- `mem_rdata` in 32: read data, valid in the cycle where `mem_req` and `mem_ready` are both high.

## Operation
- **Size and offset:** size s = 1, 2 or 4 bytes (from `funct3[1:0]`). Offset o = `addr[1:0]`. Word address W = `addr[31:2]`.
- **Split rule:** the request is split when o + s > 4.
  - First transfer covers W, lanes o..min(3, o+s-1).
  - Second transfer covers W+1 (32-bit wraparound), lanes 0..o+s-5.
- **Store path:** the 64-bit value `wdata` << 8·o is formed. Its low half drives the first transfer and its high half drives the second. Byte enables follow the lane ranges above. No read-modify-write is performed.
- **Load path:** the selected lanes from each transfer are captured into a byte-assembly register. The result is then extended:
  - funct3[2] = 0: sign extension from bit 8·s−1.
  - funct3[2] = 1: zero extension.
- **Request capture:** `start` in IDLE registers `is_store`, `funct3`, `addr` and `wdata`. `start` in any other state is ignored.
- **Illegal funct3:** load with 011/110/111, or store with funct3[2] = 1. The unit goes to DONE with `err` = 1 and issues no memory transfer.
- **FSM states:** IDLE, ACC0, ACC1, DONE.
  - IDLE → ACC0 on a legal `start`.
  - IDLE → DONE on an illegal `start`.
  - ACC0 → ACC1 on a handshake when the request is split.
  - ACC0 → DONE on a handshake when the request is not split.
  - ACC1 → DONE on a handshake.
  - DONE → IDLE unconditionally.
- **Handshake:** a transfer completes on a rising edge where `mem_req` and `mem_ready` are both 1. While waiting, `mem_addr`, `mem_be`, `mem_we` and `mem_wdata` are stable.
- **Wait counter:** reset to 0 at the start of each transfer and incremented every cycle without a handshake. When the count reaches `TIMEOUT`, `mem_req` drops, the FSM goes to DONE with `err` = 1, and `rdata` = 0.
- **Reset values:** all outputs are 0, the FSM is in IDLE, and the counter is 0.
- **Reset mid-operation:** asserting `rst` drops `mem_req` immediately (asynchronous). The partial access is abandoned and no `done` is issued.

## Timing
- All outputs are registered. No combinational path exists from `mem_ready` or `mem_rdata` to any output.
- Aligned request, `start` at edge 0:
  - `mem_req` is high during cycle 1.
  - With `mem_ready` = 1, the handshake occurs at edge 2 and `done` is high in cycle 2.
  - Latency is 2 cycles plus wait cycles.
- Split request: latency is 3 cycles plus wait cycles. `mem_req` stays continuously high across both transfers.
- Illegal request: `done` and `err` are high in cycle 1.
- `busy` is high in ACC0 and ACC1. `done` and `busy` are never high together.
- A new `start` is accepted in the cycle after `done` (IDLE). Peak throughput is one aligned access every 3 cycles.

## Test plan
- **Aligned SW then LW:** SW at `addr` 0x10, `wdata` 0xDEADBEEF, zero wait states → `mem_be` = 1111, `mem_addr` = 0x10, `done` at cycle 2. LW at 0x10 → `rdata` = 0xDEADBEEF, `err` = 0.
- **Halfword and byte extension:** SH 0xABCD at 0x06 → `mem_be` = 1100, `mem_wdata` = 0xABCD0000. LH at 0x06 → 0xFFFFABCD. LHU at 0x06 → 0x0000ABCD. SB 0xAA at 0x09, then LB → 0xFFFFFFAA and LBU → 0x000000AA.
- **Split word:** SW 0x11223344 at 0x03 → first transfer at 0x00 with `be` 1000 and `mem_wdata` 0x44000000; second at 0x04 with `be` 0111 and `mem_wdata` 0x00112233. LW at 0x03 → 0x11223344, `done` at cycle 3.
- **Wait states:** the bench holds `mem_ready` low for 3 cycles per transfer → outputs stay stable, the `busy` span grows by 3 cycles per transfer, and the data is correct.
- **Errors:** load funct3 = 011 → `done` and `err` in cycle 1 with no `mem_req`. Store funct3 = 100 → same. `mem_ready` stuck low with `TIMEOUT` = 8 → `err` = 1, `rdata` = 0, and `mem_req` low after 8 wait cycles.
- **Reset and ignored start:** assert `rst` during the ACC1 wait → `mem_req`, `busy` and `done` go to 0 immediately and the next request completes normally. A `start` pulse while `busy` → ignored, and the original access completes unchanged.
